// File: rtl/aes_uart_pkg.sv
// Shared constants and types for the AES-over-UART frame path.
// Frame = 14 payload bytes followed by a CRC-16-CCITT (MSB-first, seed FFFF, no final XOR).
// Used by both the receive and transmit sides.
package aes_uart_pkg;

  localparam int          FRAME_BYTES = 16;
  localparam int          CRC_BYTES   = 2;
  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;

  localparam int PAYLOAD_BYTES = FRAME_BYTES - CRC_BYTES;
  localparam int PAYLOAD_W     = PAYLOAD_BYTES * 8;
  localparam int FRAME_W       = FRAME_BYTES * 8;
  localparam int CRC_W         = CRC_BYTES * 8;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_RX     = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RESULT = 2'd2
  } rx_state_e;

endpackage

// File: rtl/top_rx_if.sv
// Byte-path / result bundle between the UART deserializer, the receiver and the AES core.
// master drives bytes and the check request; slave (the receiver) returns the result.
// No handshake: one byte per clock while the receiver is capturing.
interface top_rx_if;
  import aes_uart_pkg::*;

  logic [7:0]           serial_in;
  logic                 crc_en;
  logic                 valid;
  logic [PAYLOAD_W-1:0] data_out;

  modport master (
    output serial_in,
    output crc_en,
    input  valid,
    input  data_out
  );

  modport slave (
    input  serial_in,
    input  crc_en,
    output valid,
    output data_out
  );

endinterface

// File: rtl/crc16_byte_step.sv
// Advances a CRC-16 (CRC_POLY, MSB-first, non-reflected) by one whole byte.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to register the result.
module crc16_byte_step
  import aes_uart_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_work;

  // Eight unrolled shift/XOR steps with the byte pre-aligned under the CRC MSB.
  always_comb begin
    crc_work = crc_i ^ {data_i, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (crc_work[15]) begin
        crc_work = {crc_work[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_work = {crc_work[14:0], 1'b0};
      end
    end
    crc_o = crc_work;
  end

endmodule

// File: rtl/top_rx.sv
// Captures a 16-byte frame (14 payload + CRC-16), checks the CRC on request, publishes payload + valid.
// Capture takes 16 cycles; result appears one cycle after crc_en is seen in HOLD.
// No backpressure on the byte path: every RX cycle consumes serial_in; HOLD ignores it until crc_en.
module top_rx
  import aes_uart_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  top_rx_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] PAY_CNT  = CNT_W'(PAYLOAD_BYTES);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [15:0]          crc_q, crc_d;
  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;
  logic [15:0]          crc_step;

  // The running CRC folds the current incoming byte; only payload bytes are accepted into crc_q.
  crc16_byte_step u_crc_step (
    .crc_i  (crc_q),
    .data_i (bus.serial_in),
    .crc_o  (crc_step)
  );

  // State, counter, frame, CRC and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RX;
      cnt_q   <= '0;
      frame_q <= '0;
      crc_q   <= CRC_INIT;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      crc_q   <= crc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: capture in RX, wait for a request in HOLD, hold the result while requested.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    crc_d   = crc_q;
    valid_d = valid_q;
    data_d  = data_q;

    case (state_q)
      ST_RX: begin
        // Shift in from the LSB end so the first byte ends up at the top of the frame.
        frame_d = {frame_q[FRAME_W-9:0], bus.serial_in};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q < PAY_CNT) begin
          crc_d = crc_step;
        end
        if (cnt_q == LAST_CNT) begin
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        // Result registers load on the same edge that enters RESULT, giving one cycle of latency.
        if (bus.crc_en) begin
          state_d = ST_RESULT;
          data_d  = frame_q[FRAME_W-1 -: PAYLOAD_W];
          valid_d = (crc_q == frame_q[CRC_W-1:0]);
        end
      end

      ST_RESULT: begin
        // data_out is deliberately left alone so the AES core can still read the last payload.
        if (!bus.crc_en) begin
          state_d = ST_RX;
          cnt_d   = '0;
          crc_d   = CRC_INIT;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_RX;
      end
    endcase
  end

  assign bus.valid    = valid_q;
  assign bus.data_out = data_q;

endmodule

// File: tb/tb_top_rx.sv
// Self-checking bench for top_rx: directed frames from the test plan plus randomized frames.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected results come from a bit-serial CRC model and the received byte list.
module tb_top_rx;
  import aes_uart_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  top_rx_if bus ();

  top_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]           fr [FRAME_BYTES];
  logic                 exp_valid;
  logic [PAYLOAD_W-1:0] exp_data;

  task automatic chk(input string tag, input logic [PAYLOAD_W-1:0] got, input logic [PAYLOAD_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_valid"}, PAYLOAD_W'(bus.valid), PAYLOAD_W'(exp_valid));
    chk({tag, "_data"}, bus.data_out, exp_data);
  endtask

  // CRC over the payload treated as one long MSB-first bit stream.
  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    logic        fb;
    c = CRC_INIT;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ fr[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ CRC_POLY;
      end
    end
    return c;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] payload_of();
    logic [PAYLOAD_W-1:0] p;
    p = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) p = {p[PAYLOAD_W-9:0], fr[i]};
    return p;
  endfunction

  task automatic build_frame(input bit corrupt);
    logic [15:0] c;
    c = model_crc();
    if (corrupt) c = c ^ 16'h0001;
    fr[14] = c[15:8];
    fr[15] = c[7:0];
  endtask

  task automatic fill_random();
    for (int i = 0; i < PAYLOAD_BYTES; i++) fr[i] = 8'($urandom);
  endtask

  task automatic fill_literal(input logic [PAYLOAD_W-1:0] p);
    for (int i = 0; i < PAYLOAD_BYTES; i++) fr[i] = p[PAYLOAD_W-1-8*i -: 8];
  endtask

  // Called just after a falling edge with the receiver in RX; returns the same way.
  task automatic run_frame(input string tag, input int early_at, input int hold_wait, input int res_cycles);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (i == early_at) bus.crc_en = 1'b1;
      bus.serial_in = fr[i];
      @(negedge clk);
      chk_outs({tag, "_cap"});
    end
    if (early_at < 0) begin
      for (int w = 0; w < hold_wait; w++) begin
        bus.serial_in = 8'($urandom);
        @(negedge clk);
        chk_outs({tag, "_hold"});
      end
      bus.crc_en = 1'b1;
    end
    bus.serial_in = 8'($urandom);
    exp_data  = payload_of();
    exp_valid = (model_crc() == {fr[14], fr[15]});
    @(negedge clk);
    chk_outs({tag, "_res"});
    for (int r = 1; r < res_cycles; r++) begin
      bus.serial_in = 8'($urandom);
      @(negedge clk);
      chk_outs({tag, "_res_held"});
    end
    bus.crc_en = 1'b0;
    @(negedge clk);
    exp_valid = 1'b0;
    chk_outs({tag, "_drop"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.serial_in = 8'h00;
    bus.crc_en    = 1'b0;
    exp_valid     = 1'b0;
    exp_data      = '0;

    // Reset held for two cycles; outputs must sit at zero.
    @(negedge clk);
    chk_outs("reset0");
    @(negedge clk);
    chk_outs("reset1");
    reset = 1'b0;

    // Good frame from the test plan, request raised after two idle HOLD cycles.
    fill_literal(112'h1d5a6621527f5b226bf0e97205a6);
    build_frame(1'b0);
    run_frame("good", -1, 2, 3);
    chk("good_payload_literal", payload_of(), 112'h1d5a6621527f5b226bf0e97205a6);

    // Same payload with the low CRC bit flipped.
    build_frame(1'b1);
    run_frame("corrupt", -1, 1, 2);

    // Request held high from byte 5: result must only appear after HOLD is reached.
    build_frame(1'b0);
    run_frame("early", 5, 0, 2);

    // Back-to-back frame of all A5.
    for (int i = 0; i < PAYLOAD_BYTES; i++) fr[i] = 8'hA5;
    build_frame(1'b0);
    run_frame("a5", -1, 0, 2);
    chk("a5_data_literal", bus.data_out, {14{8'hA5}});

    // Reset after byte 7, then a fresh full frame.
    fill_random();
    build_frame(1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.serial_in = fr[i];
      @(negedge clk);
      chk_outs("midrst_cap");
    end
    reset = 1'b1;
    #1;
    exp_valid = 1'b0;
    exp_data  = '0;
    chk_outs("midrst_async");
    @(negedge clk);
    reset = 1'b0;
    fill_random();
    build_frame(1'b0);
    run_frame("midrst", -1, 1, 2);

    // Randomized frames: random payload, occasional corruption, random timing of the request.
    for (int n = 0; n < 12; n++) begin
      fill_random();
      build_frame($urandom_range(0, 2) == 0);
      run_frame("rand",
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1,
                int'($urandom_range(0, 3)),
                int'($urandom_range(1, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
